cla_adder_pipe: RTL and testbench

- Parametrised, two-stage pipelined carry-lookahead adder/subtractor with valid/ready handshakes on input and output.
- Built from 4-bit lookahead groups, each producing group propagate and group generate, combined by a second-level lookahead carry unit.
- Next-generation arithmetic datapath block for the lab CPU ALU; throughput is one operation per cycle, with full backpressure.

---
 rtl/cla_adder_pipe.sv | 197 +++++++++++++++++++
 tb/tb_cla_adder_pipe.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cla_adder_pipe.sv
// Two-stage pipelined carry-lookahead adder/subtractor.
// Stage 1 registers the operands with per-bit propagate/generate and per-group
// PG/GG terms. Stage 2 runs the second-level lookahead to get group carries,
// expands them into bit carries inside each 4-bit group, and registers the result.
// A valid/ready handshake on each side gives one operation per cycle with full
// backpressure.
`timescale 1ns/1ps
module cla_adder_pipe #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf,
    output logic             out_zero,
    output logic             out_pg,
    output logic             out_gg
);

    localparam int GROUPS = WIDTH / 4;

    // Refuse to elaborate with a width that does not split into whole 4-bit groups.
    if (WIDTH < 4 || (WIDTH % 4) != 0) begin : g_width_check
        $error("cla_adder_pipe: WIDTH must be a multiple of 4 and at least 4");
    end

    // Carry out of group k, flattened into sum-of-products form: no term
    // depends on the carry out of a lower group, so there is no ripple chain.
    function automatic logic group_carry(
        input logic [GROUPS-1:0] pg,
        input logic [GROUPS-1:0] gg,
        input logic              cin,
        input int                k
    );
        logic acc;
        logic prop;
        acc = 1'b0;
        for (int j = 0; j <= k; j++) begin
            prop = 1'b1;
            for (int m = j + 1; m <= k; m++) begin
                prop = prop & pg[m];
            end
            acc = acc | (gg[j] & prop);
        end
        prop = 1'b1;
        for (int m = 0; m <= k; m++) begin
            prop = prop & pg[m];
        end
        return acc | (prop & cin);
    endfunction

    // ------------------------------------------------------------------
    // Pipeline control: everything moves together when the output slot is
    // free or being drained this cycle.
    // ------------------------------------------------------------------
    logic w_adv;
    assign w_adv    = !out_valid || out_ready;
    assign in_ready = w_adv;

    // ------------------------------------------------------------------
    // Stage 1 combinational: effective operands and propagate/generate terms
    // ------------------------------------------------------------------
    logic [WIDTH-1:0]  w_b_eff;
    logic [WIDTH-1:0]  w_p;
    logic [WIDTH-1:0]  w_g;
    logic              w_c0;
    logic [GROUPS-1:0] w_pg;
    logic [GROUPS-1:0] w_gg;

    assign w_b_eff = in_sub ? ~in_b : in_b;
    assign w_c0    = in_sub ? ~in_cin : in_cin;
    assign w_p     = in_a ^ w_b_eff;
    assign w_g     = in_a & w_b_eff;

    for (genvar gi = 0; gi < GROUPS; gi++) begin : g_grp_terms
        assign w_pg[gi] = &w_p[4*gi +: 4];
        assign w_gg[gi] = w_g[4*gi+3]
                        | (w_p[4*gi+3] & w_g[4*gi+2])
                        | (w_p[4*gi+3] & w_p[4*gi+2] & w_g[4*gi+1])
                        | (w_p[4*gi+3] & w_p[4*gi+2] & w_p[4*gi+1] & w_g[4*gi]);
    end

    logic [WIDTH-1:0]  r_a;
    logic [WIDTH-1:0]  r_b;
    logic              r_c0;
    logic [WIDTH-1:0]  r_p;
    logic [WIDTH-1:0]  r_g;
    logic [GROUPS-1:0] r_pg;
    logic [GROUPS-1:0] r_gg;
    logic              r_s1_valid;

    // Stage 1 register: captures the operand (or a bubble) whenever the pipe advances.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a        <= '0;
            r_b        <= '0;
            r_c0       <= 1'b0;
            r_p        <= '0;
            r_g        <= '0;
            r_pg       <= '0;
            r_gg       <= '0;
            r_s1_valid <= 1'b0;
        end else if (w_adv) begin
            r_a        <= in_a;
            r_b        <= w_b_eff;
            r_c0       <= w_c0;
            r_p        <= w_p;
            r_g        <= w_g;
            r_pg       <= w_pg;
            r_gg       <= w_gg;
            r_s1_valid <= in_valid;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2 combinational: group carries, bit carries, result flags
    // ------------------------------------------------------------------
    logic [GROUPS:0]  w_cg;   // w_cg[k] = carry into group k
    logic [WIDTH-1:0] w_c;    // w_c[i]  = carry into bit i
    logic [WIDTH-1:0] w_sum;
    logic             w_ovf;
    logic             w_zero;
    logic             w_pg_word;
    logic             w_gg_word;

    assign w_cg[0] = r_c0;

    for (genvar gi = 0; gi < GROUPS; gi++) begin : g_carry
        assign w_cg[gi+1] = group_carry(r_pg, r_gg, r_c0, gi);

        // Full 4-bit lookahead inside the group from the group's carry-in.
        assign w_c[4*gi]   = w_cg[gi];
        assign w_c[4*gi+1] = r_g[4*gi]
                           | (r_p[4*gi] & w_cg[gi]);
        assign w_c[4*gi+2] = r_g[4*gi+1]
                           | (r_p[4*gi+1] & r_g[4*gi])
                           | (r_p[4*gi+1] & r_p[4*gi] & w_cg[gi]);
        assign w_c[4*gi+3] = r_g[4*gi+2]
                           | (r_p[4*gi+2] & r_g[4*gi+1])
                           | (r_p[4*gi+2] & r_p[4*gi+1] & r_g[4*gi])
                           | (r_p[4*gi+2] & r_p[4*gi+1] & r_p[4*gi] & w_cg[gi]);
    end

    assign w_sum     = r_a ^ r_b ^ w_c;
    assign w_ovf     = w_c[WIDTH-1] ^ w_cg[GROUPS];
    assign w_zero    = ~|w_sum;
    assign w_pg_word = &r_pg;
    // Word generate is the word carry-out with the carry-in forced to zero.
    assign w_gg_word = group_carry(r_pg, r_gg, 1'b0, GROUPS - 1);

    logic             r_out_valid;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_ovf;
    logic             r_zero;
    logic             r_pg_word;
    logic             r_gg_word;

    // Stage 2 / output register: loads only on advance so a stalled result holds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_sum       <= '0;
            r_cout      <= 1'b0;
            r_ovf       <= 1'b0;
            r_zero      <= 1'b0;
            r_pg_word   <= 1'b0;
            r_gg_word   <= 1'b0;
        end else if (w_adv) begin
            r_out_valid <= r_s1_valid;
            r_sum       <= w_sum;
            r_cout      <= w_cg[GROUPS];
            r_ovf       <= w_ovf;
            r_zero      <= w_zero;
            r_pg_word   <= w_pg_word;
            r_gg_word   <= w_gg_word;
        end
    end

    assign out_valid = r_out_valid;
    assign out_sum   = r_sum;
    assign out_cout  = r_cout;
    assign out_ovf   = r_ovf;
    assign out_zero  = r_zero;
    assign out_pg    = r_pg_word;
    assign out_gg    = r_gg_word;

endmodule

// File: tb/tb_cla_adder_pipe.sv
// Bench for cla_adder_pipe: three instances (WIDTH 4, 16, 32). Directed cases
// run on the 16-bit instance, then all three take 1000 random operands with
// random output backpressure. Expected results come from an integer-arithmetic
// model and are compared by a scoreboard monitor as results retire.
`timescale 1ns/1ps
module tb_cla_adder_pipe;

    localparam int NI = 3;
    localparam int D  = 1;    // instance used for directed cases (WIDTH=16)
    localparam int NRAND = 1000;

    typedef struct packed {
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
        logic        zero;
        logic        pg;
        logic        gg;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [NI-1:0]   in_valid;
    wire  [NI-1:0]   in_ready;
    logic [31:0]     in_a [NI];
    logic [31:0]     in_b [NI];
    logic [NI-1:0]   in_cin;
    logic [NI-1:0]   in_sub;
    wire  [NI-1:0]   out_valid;
    logic [NI-1:0]   out_ready;
    wire  [31:0]     out_sum [NI];
    wire  [NI-1:0]   out_cout;
    wire  [NI-1:0]   out_ovf;
    wire  [NI-1:0]   out_zero;
    wire  [NI-1:0]   out_pg;
    wire  [NI-1:0]   out_gg;

    int   total = 0;
    int   bad   = 0;
    exp_t sb [NI][$];
    logic rand_phase = 1'b0;

    initial forever #5 clk = ~clk;

    for (genvar gi = 0; gi < NI; gi++) begin : g_dut
        localparam int W = (gi == 0) ? 4 : ((gi == 1) ? 16 : 32);
        logic [W-1:0] w_sum;
        cla_adder_pipe #(.WIDTH(W)) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (in_valid[gi]),
            .in_ready  (in_ready[gi]),
            .in_a      (in_a[gi][W-1:0]),
            .in_b      (in_b[gi][W-1:0]),
            .in_cin    (in_cin[gi]),
            .in_sub    (in_sub[gi]),
            .out_valid (out_valid[gi]),
            .out_ready (out_ready[gi]),
            .out_sum   (w_sum),
            .out_cout  (out_cout[gi]),
            .out_ovf   (out_ovf[gi]),
            .out_zero  (out_zero[gi]),
            .out_pg    (out_pg[gi]),
            .out_gg    (out_gg[gi])
        );
        assign out_sum[gi] = 32'(w_sum);
    end

    function automatic int wof(int i);
        return (i == 0) ? 4 : ((i == 1) ? 16 : 32);
    endfunction

    // Reference: plain integer arithmetic on wide values.
    function automatic exp_t model(int w, logic [31:0] a, logic [31:0] b, logic cin, logic sub);
        exp_t e;
        longint unsigned mask, ua, ub, beff, full;
        longint sa, sbv, ci, res, lim;
        mask = (64'd1 << w) - 64'd1;
        ua   = 64'(a) & mask;
        ub   = 64'(b) & mask;
        beff = sub ? (~ub & mask) : ub;
        full = ua + beff + ((sub ? !cin : cin) ? 64'd1 : 64'd0);
        lim  = longint'(64'd1 << (w - 1));
        sa   = longint'(ua);
        if (sa >= lim) sa = sa - 2 * lim;
        sbv  = longint'(ub);
        if (sbv >= lim) sbv = sbv - 2 * lim;
        ci   = cin ? 1 : 0;
        res  = sub ? (sa - sbv - ci) : (sa + sbv + ci);
        e.sum  = 32'(full & mask);
        e.cout = ((full >> w) & 64'd1) != 0;
        e.ovf  = (res >= lim) || (res < -lim);
        e.zero = (full & mask) == 0;
        e.pg   = (ua ^ beff) == mask;
        e.gg   = (((ua + beff) >> w) & 64'd1) != 0;
        return e;
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Present one operand, hold it until accepted, record the expected result.
    task automatic send(int i, logic [31:0] a, logic [31:0] b, logic cin, logic sub);
        int n;
        logic ok;
        in_a[i] = a; in_b[i] = b; in_cin[i] = cin; in_sub[i] = sub;
        in_valid[i] = 1'b1;
        n = 0;
        ok = 1'b0;
        while (!ok && n < 200) begin
            @(negedge clk);
            if (in_ready[i]) ok = 1'b1;
            n++;
        end
        if (ok) begin
            sb[i].push_back(model(wof(i), a, b, cin, sub));
        end else begin
            total++; bad++;
            $display("FAIL accept_timeout inst=%0d actual=in_ready0 required=in_ready1", i);
        end
        @(posedge clk); #1;
        in_valid[i] = 1'b0;
    endtask

    task automatic tick(int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic wait_drain(int max);
        int n = 0;
        while ((sb[0].size() + sb[1].size() + sb[2].size()) != 0 && n < max) begin
            @(posedge clk); #1; n++;
        end
        for (int i = 0; i < NI; i++) chk($sformatf("drain_inst%0d", i), 64'(sb[i].size()), 64'd0);
    endtask

    task automatic run_rand(int i);
        int w;
        logic [31:0] mask, a, b;
        w = wof(i);
        mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        for (int n = 0; n < NRAND; n++) begin
            case ($urandom_range(0, 7))
                0: a = 32'd0;
                1: a = mask;
                2: a = 32'd1 << (w - 1);
                default: a = $urandom;
            endcase
            b = ($urandom_range(0, 7) == 0) ? mask : $urandom;
            send(i, a & mask, b & mask, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) tick(1);
        end
    endtask

    // Scoreboard monitor: a result retires when out_valid and out_ready both hold.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < NI; i++) begin
                if (out_valid[i] && out_ready[i]) begin
                    exp_t act, e;
                    act = '{sum: out_sum[i], cout: out_cout[i], ovf: out_ovf[i],
                            zero: out_zero[i], pg: out_pg[i], gg: out_gg[i]};
                    total++;
                    if (sb[i].size() == 0) begin
                        bad++;
                        $display("FAIL spurious_result inst=%0d actual=%h required=none", i, act);
                    end else begin
                        e = sb[i].pop_front();
                        if (act !== e) begin
                            bad++;
                            $display("FAIL result inst=%0d actual=%h required=%h (sum,cout,ovf,zero,pg,gg)", i, act, e);
                        end else begin
                            $display("txn inst=%0d w=%0d sum=%h cout=%b ovf=%b zero=%b pg=%b gg=%b",
                                     i, wof(i), act.sum, act.cout, act.ovf, act.zero, act.pg, act.gg);
                        end
                    end
                end
            end
        end
    end

    // Random backpressure during the random phase.
    initial forever begin
        @(posedge clk); #1;
        if (rand_phase)
            for (int i = 0; i < NI; i++) out_ready[i] = ($urandom_range(0, 3) != 0);
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst_n = 1'b0;
        in_valid = '0; in_cin = '0; in_sub = '0; out_ready = '1;
        for (int i = 0; i < NI; i++) begin in_a[i] = '0; in_b[i] = '0; end
        tick(3);
        // Reset state
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_ready", 64'(in_ready), 64'h7);
        chk("rst_sum",   64'(out_sum[D]), 64'd0);
        chk("rst_flags", 64'({out_cout, out_ovf, out_zero, out_pg, out_gg}), 64'd0);
        rst_n = 1'b1;
        tick(1);

        // 1: plain add, result after two edges
        send(D, 32'h1234, 32'h4321, 1'b0, 1'b0);
        tick(1);
        chk("t1_valid", 64'(out_valid[D]), 64'd1);
        chk("t1_sum",   64'(out_sum[D]), 64'h5555);
        chk("t1_cout_ovf_zero", 64'({out_cout[D], out_ovf[D], out_zero[D]}), 64'd0);
        tick(1);

        // 2: full propagate with carry-in
        send(D, 32'hFFFF, 32'h0000, 1'b1, 1'b0);
        tick(1);
        chk("t2_sum", 64'(out_sum[D]), 64'h0000);
        chk("t2_cout_zero_pg_gg", 64'({out_cout[D], out_zero[D], out_pg[D], out_gg[D]}), 64'b1110);
        tick(1);

        // 3: subtraction with overflow, then a borrow
        send(D, 32'h8000, 32'h0001, 1'b0, 1'b1);
        tick(1);
        chk("t3a_sum", 64'(out_sum[D]), 64'h7FFF);
        chk("t3a_cout_ovf", 64'({out_cout[D], out_ovf[D]}), 64'b11);
        tick(1);
        send(D, 32'h0003, 32'h0005, 1'b0, 1'b1);
        tick(1);
        chk("t3b_sum", 64'(out_sum[D]), 64'hFFFE);
        chk("t3b_cout", 64'(out_cout[D]), 64'd0);
        wait_drain(20);

        // 4: back-to-back stream with a 3-cycle output stall
        fork
            begin
                for (int i = 0; i < 4; i++) send(D, 32'(i + 1), 32'(i + 1), 1'b0, 1'b0);
            end
            begin
                n = 0;
                while (!out_valid[D] && n < 20) begin @(posedge clk); #1; n++; end
                chk("t4_first_valid", 64'(out_valid[D]), 64'd1);
                out_ready[D] = 1'b0;
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk);
                    chk("t4_hold_ready", 64'(in_ready[D]), 64'd0);
                    chk("t4_hold_sum",   64'(out_sum[D]), 64'h0002);
                    chk("t4_hold_valid", 64'(out_valid[D]), 64'd1);
                    @(posedge clk); #1;
                end
                out_ready[D] = 1'b1;
            end
        join
        wait_drain(30);

        // 5: asynchronous reset while two operands are in flight
        send(D, 32'h0101, 32'h0202, 1'b0, 1'b0);
        send(D, 32'h0404, 32'h0808, 1'b0, 1'b0);
        chk("t5_pre_valid", 64'(out_valid[D]), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_valid", 64'(out_valid[D]), 64'd0);
        chk("t5_ready", 64'(in_ready[D]), 64'd1);
        chk("t5_sum",   64'(out_sum[D]), 64'd0);
        chk("t5_flags", 64'({out_cout[D], out_ovf[D], out_zero[D], out_pg[D], out_gg[D]}), 64'd0);
        for (int i = 0; i < NI; i++) sb[i].delete();
        tick(1);
        #2 rst_n = 1'b1;
        tick(4);
        chk("t5_no_stale", 64'(out_valid[D]), 64'd0);
        send(D, 32'h00FF, 32'h0001, 1'b0, 1'b0);
        wait_drain(20);

        // 6: random operands on all widths with random backpressure
        rand_phase = 1'b1;
        fork
            run_rand(0);
            run_rand(1);
            run_rand(2);
        join
        rand_phase = 1'b0;
        out_ready = '1;
        wait_drain(50);
        tick(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
